// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, USR bit indices
// and oversampling constants. Build with UART_RX_PARITY_EN for 8E1 framing.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam int USR_RXC = 0;
   localparam int USR_ERR = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } rx_state_e;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-clock tick every CLK_DIV clocks.
// Shared by the receive core and the future transmitter.
module uart_baud_gen #(
   parameter int CLK_DIV = 27
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver producing USR (RXC/ERR) and UDRR for the CPU.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 with parity checking.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_DIV     = 27,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       udrr_rd,
   output logic [1:0] USR,
   output logic [7:0] UDRR,
   output logic       busy
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);

   logic [SYNC_STAGES-1:0] rx_sync;
   logic                   rx_s;
   logic                   tick;

   rx_state_e  state, state_nx;
   logic [3:0] tick_cnt, tick_cnt_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [7:0] shift_reg, shift_nx;
   logic       armed, armed_nx;
   logic       frame_done;
   logic       stop_bad;
   logic       bit_end;
   logic       new_err;
`ifdef UART_RX_PARITY_EN
   logic       par_err, par_err_nx;
`endif

   // Synchroniser resets to the idle level so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync <= '1;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = rx_sync[SYNC_STAGES-1];

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         tick_cnt  <= tick_cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         shift_reg <= shift_nx;
         armed     <= armed_nx;
`ifdef UART_RX_PARITY_EN
         par_err   <= par_err_nx;
`endif
      end
   end

   assign bit_end = tick && (tick_cnt == LAST_TICK);

   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      bit_cnt_nx  = bit_cnt;
      shift_nx    = shift_reg;
      armed_nx    = armed;
      frame_done  = 1'b0;
      stop_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_nx  = par_err;
`endif
      case (state)
         // armed only after rx has been seen high, so a held-low break cannot restart a frame
         ST_IDLE: begin
            if (rx_s) begin
               armed_nx = 1'b1;
            end else if (armed) begin
               state_nx    = ST_START;
               tick_cnt_nx = '0;
               bit_cnt_nx  = '0;
               armed_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
               par_err_nx  = 1'b0;
`endif
            end
         end
         ST_START: begin
            if (tick) begin
               if (tick_cnt == MID_TICK) begin
                  tick_cnt_nx = '0;
                  state_nx    = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt_nx = tick_cnt + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               tick_cnt_nx = tick_cnt + 4'd1;
            end
            if (bit_end) begin
               shift_nx   = {rx_s, shift_reg[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nx = ST_PARITY;
`else
                  state_nx = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               tick_cnt_nx = tick_cnt + 4'd1;
            end
            if (bit_end) begin
               par_err_nx = (rx_s != even_parity(shift_reg));
               state_nx   = ST_STOP;
            end
         end
`endif
         // Leave at the mid-stop sample so the next start edge is never missed.
         ST_STOP: begin
            if (tick) begin
               tick_cnt_nx = tick_cnt + 4'd1;
            end
            if (bit_end) begin
               frame_done = 1'b1;
               stop_bad   = !rx_s;
               state_nx   = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign new_err = stop_bad | par_err;
`else
   assign new_err = stop_bad;
`endif

   // A completing frame beats a simultaneous read; the read only drops the old overrun/error history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         USR  <= 2'b00;
         UDRR <= 8'h00;
      end else if (frame_done) begin
         UDRR         <= shift_reg;
         USR[USR_RXC] <= 1'b1;
         USR[USR_ERR] <= new_err | (!udrr_rd & (USR[USR_ERR] | USR[USR_RXC]));
      end else if (udrr_rd) begin
         USR <= 2'b00;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames from the test plan plus randomized
// frames, checked against a frame-level model of the status/data registers.
module tb_uart_rx_core;

   localparam int CLK_DIV  = 4;
   localparam int BIT_CLKS = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       udrr_rd = 1'b0;
   logic [1:0] USR;
   logic [7:0] UDRR;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic       exp_rxc = 1'b0;
   logic       exp_err = 1'b0;
   logic [7:0] exp_udrr = 8'h00;
   logic [7:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   uart_rx_core #(
      .CLK_DIV     (CLK_DIV),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (rx),
      .udrr_rd (udrr_rd),
      .USR     (USR),
      .UDRR    (UDRR),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: frame-level register behaviour
   function automatic logic good_parity(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
      logic bad;
      bad = !stop_bit;
`ifdef UART_RX_PARITY_EN
      if ((($countones(d) + int'(par_bit)) % 2) != 0) bad = 1'b1;
`endif
      exp_err = exp_err | exp_rxc | bad;
      exp_rxc = 1'b1;
      exp_q.push_back(d);
   endtask

   task automatic model_read();
      exp_rxc = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic model_reset();
      exp_rxc  = 1'b0;
      exp_err  = 1'b0;
      exp_udrr = 8'h00;
      exp_q.delete();
   endtask

   // drivers
   task automatic drive_bits(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit, input int gap);
      drive_bits(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
      drive_bits(par_bit, BIT_CLKS);
`endif
      drive_bits(stop_bit, BIT_CLKS);
      model_frame(d, stop_bit, par_bit);
      drive_bits(1'b1, gap);
   endtask

   task automatic do_read();
      @(negedge clk);
      udrr_rd = 1'b1;
      @(negedge clk);
      udrr_rd = 1'b0;
      model_read();
   endtask

   // scoreboard
   task automatic check_outputs(input string tag);
      while (exp_q.size() > 0) exp_udrr = exp_q.pop_front();
      check({tag, "_usr"}, 32'(USR), 32'({exp_err, exp_rxc}));
      check({tag, "_udrr"}, 32'(UDRR), 32'(exp_udrr));
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic       stop_bit;
      logic       par_bit;

      repeat (3) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;
      drive_bits(1'b1, 20);

      send_frame(8'hA5, 1'b1, good_parity(8'hA5), 16);
      check_outputs("a5");
      do_read();
      check_outputs("a5_read");

      send_frame(8'h3C, 1'b0, good_parity(8'h3C), BIT_CLKS);
      check_outputs("stop_low");
      do_read();

      send_frame(8'h11, 1'b1, good_parity(8'h11), 8);
      send_frame(8'h22, 1'b1, good_parity(8'h22), 8);
      check_outputs("overrun");

      drive_bits(1'b0, 3 * CLK_DIV);
      check("glitch_busy", 32'(busy), 32'd1);
      drive_bits(1'b1, BIT_CLKS);
      check_outputs("glitch");

      // reset in the middle of data bit 4 of 0xFF
      drive_bits(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive_bits(1'b1, BIT_CLKS);
      drive_bits(1'b1, BIT_CLKS / 2);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("mid_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drive_bits(1'b1, BIT_CLKS);
      send_frame(8'h5A, 1'b1, good_parity(8'h5A), 8);
      check_outputs("after_reset");
      do_read();

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 8);
      check_outputs("par_bad");
      do_read();
      send_frame(8'h07, 1'b1, 1'b1, 8);
      check_outputs("par_good");
      do_read();
`endif

      for (int n = 0; n < 24; n++) begin
         d        = 8'($urandom_range(0, 255));
         stop_bit = ($urandom_range(0, 7) != 0);
         par_bit  = good_parity(d) ^ ($urandom_range(0, 7) == 0);
         send_frame(d, stop_bit, par_bit, $urandom_range(1, BIT_CLKS));
         check_outputs("rand");
         if ($urandom_range(0, 1) == 1) begin
            do_read();
            check_outputs("rand_read");
         end
      end

      // break: line held low well past a frame, then released
      do_read();
      drive_bits(1'b0, FRAME_BITS * BIT_CLKS);
      model_frame(8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_bits(1'b0, BIT_CLKS);
         check("break_idle", 32'(busy), 32'd0);
      end
      check_outputs("break");
      drive_bits(1'b1, BIT_CLKS);
      do_read();
      send_frame(8'hC3, 1'b1, good_parity(8'hC3), 8);
      check_outputs("after_break");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
